// File: rtl/addacc_pkg.sv
// Shared definitions for the addacc_pipe block.
//   mode_e  : operating mode carried with each operand pair
//   sat_add : unsigned add of two values truncated to w bits, returning
//             {carry, value} where value clamps to all-ones on overflow
package addacc_pkg;

  typedef enum logic [1:0] {
    ADD_WRAP = 2'd0,
    ADD_SAT  = 2'd1,
    ACC_WRAP = 2'd2,
    ACC_SAT  = 2'd3
  } mode_e;

  // Widest operand the helper supports; callers zero-extend into it.
  localparam int unsigned MAX_W = 64;

  function automatic logic [MAX_W:0] sat_add(input logic [MAX_W-1:0] x,
                                             input logic [MAX_W-1:0] y,
                                             input int unsigned      w);
    logic [MAX_W:0] s;
    logic [MAX_W:0] mask;
    logic           c;
    s    = {1'b0, x} + {1'b0, y};
    mask = ({{MAX_W{1'b0}}, 1'b1} << w) - 1'b1;
    // Anything above bit w-1 means the w-bit sum overflowed.
    c    = |(s & ~mask);
    return {c, c ? mask[MAX_W-1:0] : (s[MAX_W-1:0] & mask[MAX_W-1:0])};
  endfunction

endpackage

// File: rtl/addacc_core.sv
// Combinational datapath of addacc_pipe: given the operands, the current
// accumulator and the mode, produce the next accumulator, the result and
// its carry. Holds no state.
//   a_i, b_i   : unsigned operands
//   acc_i      : accumulator value to build on (already zeroed on clear)
//   mode_i     : operating mode
//   acc_o      : next accumulator (equals acc_i in ADD modes)
//   sum_o      : result value
//   carry_o    : unsigned overflow of this result's addition
module addacc_core
  import addacc_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] acc_i,
  input  mode_e            mode_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  logic [MAX_W:0]   add_r;
  logic [WIDTH+1:0] acc_raw;
  logic             acc_ovf;
  logic             unused_add_hi;

  always_comb begin
    add_r   = sat_add(MAX_W'(a_i), MAX_W'(b_i), WIDTH);
    // Three WIDTH-bit terms need two extra bits before overflow is judged.
    acc_raw = {2'b00, acc_i} + {2'b00, a_i} + {2'b00, b_i};
    acc_ovf = |acc_raw[WIDTH+1:WIDTH];

    acc_o   = acc_i;
    sum_o   = add_r[WIDTH-1:0];
    carry_o = add_r[MAX_W];
    unique case (mode_i)
      ADD_WRAP: begin
        // Saturated value differs from the wrapped one only on overflow.
        sum_o = a_i + b_i;
      end
      ADD_SAT: begin
        sum_o = add_r[WIDTH-1:0];
      end
      ACC_WRAP: begin
        acc_o   = acc_raw[WIDTH-1:0];
        sum_o   = acc_raw[WIDTH-1:0];
        carry_o = acc_ovf;
      end
      ACC_SAT: begin
        acc_o   = acc_ovf ? {WIDTH{1'b1}} : acc_raw[WIDTH-1:0];
        sum_o   = acc_ovf ? {WIDTH{1'b1}} : acc_raw[WIDTH-1:0];
        carry_o = acc_ovf;
      end
      default: ;
    endcase
  end

  // Upper helper bits are zero by construction once carry is extracted.
  assign unused_add_hi = ^add_r[MAX_W-1:WIDTH];

endmodule

// File: rtl/addacc_pipe.sv
// Registered add/accumulate unit with a valid/ready handshake on both sides.
// One result per accepted operand pair, one cycle of latency, full throughput
// while downstream is ready. No skid buffer: in_ready follows out_ready.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand pair handshake (a, b, mode, sampled together)
//   clear               : zero accumulator, count and sticky overflow
//   out_valid/out_ready : result handshake for sum and carry
//   ovf_sticky          : OR of carry over results since reset/clear
//   count               : saturating count of accumulate-mode pairs
module addacc_pipe
  import addacc_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] count
);

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q, acc_q, acc_d, acc_base, sum_d;
  logic             carry_q, carry_d, sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic             accept, is_acc;
  mode_e            mode_m;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign mode_m   = mode_e'(mode);
  assign is_acc   = (mode_m == ACC_WRAP) || (mode_m == ACC_SAT);

  // Clear acts before a same-cycle accept, so the datapath sees zeroed state.
  assign acc_base = clear ? '0 : acc_q;
  assign cnt_base = clear ? '0 : cnt_q;

  addacc_core #(.WIDTH(WIDTH)) u_core (
    .a_i    (a),
    .b_i    (b),
    .acc_i  (acc_base),
    .mode_i (mode_m),
    .acc_o  (acc_d),
    .sum_o  (sum_d),
    .carry_o(carry_d)
  );

  always_comb begin
    sticky_d = clear ? 1'b0 : sticky_q;
    cnt_d    = cnt_base;
    if (accept) begin
      sticky_d = sticky_d | carry_d;
      if (is_acc && (cnt_base != {CNT_W{1'b1}})) cnt_d = cnt_base + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      acc_q    <= accept ? acc_d : acc_base;
      if (accept) begin
        out_valid_q <= 1'b1;
        sum_q       <= sum_d;
        carry_q     <= carry_d;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign sum        = sum_q;
  assign carry      = carry_q;
  assign ovf_sticky = sticky_q;
  assign count      = cnt_q;

endmodule

// File: doc/addacc_pipe.md
Name: addacc_pipe

Overview:
Parametrised, registered successor to the top-level combinational byte adder. Accepts operand pairs over a valid/ready handshake and produces one registered result per accepted pair. Four operating modes: wrapping add, saturating add, wrapping accumulate and saturating accumulate. Tracks a sample count and a sticky overflow flag. Sits behind the tile I/O wrapper, which maps ui_in/uio_in to the operands and the result to uo_out.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
CNT_W, 4, sample-counter width in bits (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand pair present
in_ready  output  1  block can accept the pair this cycle
a  input  WIDTH  operand A, unsigned
b  input  WIDTH  operand B, unsigned
mode  input  2  0=ADD_WRAP, 1=ADD_SAT, 2=ACC_WRAP, 3=ACC_SAT; sampled with the pair
clear  input  1  zero the accumulator, count and sticky flag
out_valid  output  1  result register holds unconsumed data
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
carry  output  1  unsigned overflow of this result's addition
ovf_sticky  output  1  OR of carry over all results since reset/clear
count  output  CNT_W  accumulate-mode samples since reset/clear, saturating

Behaviour:
- Reset (rst=1 at a clk edge) forces the following to 0: out_valid, sum, carry, ovf_sticky, count, accumulator. in_ready is 1 in the cycle after reset.
- in_ready = !out_valid || out_ready (combinational). No skid buffer.
- Accept: in_valid && in_ready at a clk edge. Latency is 1 cycle, so sum is valid the next cycle. Throughput is 1 per cycle while out_ready=1.
- Output hold: while out_valid && !out_ready, sum and carry are held stable. out_valid deasserts only on a consume edge with no new accept.
- Arithmetic, with raw = WIDTH+1-bit unsigned sum:
  - ADD_WRAP: raw=a+b; sum=raw[WIDTH-1:0]; carry=raw[WIDTH].
  - ADD_SAT: raw=a+b; sum=all-ones if raw[WIDTH], else raw; carry=raw[WIDTH].
  - ACC_WRAP: raw=acc+a+b, computed in WIDTH+2 bits; acc<=raw mod 2^WIDTH; sum=new acc; carry=1 if raw>=2^WIDTH.
  - ACC_SAT: as ACC_WRAP, but acc and sum clamp to all-ones when raw>=2^WIDTH; carry=1 in that case.
  - b is ignored when it is 0; no special case.
- ADD modes never modify acc or count.
- count increments on each accepted ACC-mode pair and saturates at 2^CNT_W-1.
- ovf_sticky <= ovf_sticky | carry at each accept.
- Mode change between accepts is legal. acc persists across mode changes.
- clear=1 at an edge zeros acc, count and ovf_sticky.
- clear together with an accept in the same cycle: clear applies first, then the accept uses acc=0. The result and sticky reflect only that pair, and count becomes 1 if in ACC mode.
- clear does not affect out_valid, sum or carry.
- rst mid-operation discards any pending result (out_valid=0) and has priority over clear and accept.
- No combinational path from a, b or mode to any output. Only in_ready depends combinationally, on out_ready.

Decomposition:
- Shared package addacc_pkg: mode enum (ADD_WRAP, ADD_SAT, ACC_WRAP, ACC_SAT) and a function sat_add(x, y, width-parametrised) returning {carry, value}.
- One sub-module, addacc_core: purely combinational, computes next acc, sum and carry from a, b, acc and mode. The top level holds the registers and handshake.

Test Plan (WIDTH=8, CNT_W=4):
- Reset: assert rst 2 cycles -> out_valid=0, sum=0, count=0, ovf_sticky=0; in_ready=1 after release.
- ADD_WRAP a=200, b=100, out_ready=1 -> next cycle sum=44, carry=1, ovf_sticky=1, count=0. Then ADD_SAT with the same operands -> sum=255, carry=1.
- ACC_WRAP pairs (10,5), (20,0), (250,0) -> sums 15, 35, 29. Carry on the third only. count=3.
- Backpressure: out_ready=0 with in_valid=1 for 3 cycles -> one accept only, sum held, in_ready=0. out_ready=1 -> stream resumes with no loss or duplication.
- clear plus ACC_SAT accept of (7,1) with acc=100 -> sum=8, count=1, ovf_sticky=0. Then 16 further ACC pairs -> count saturates at 15.
- rst asserted while out_valid=1 and out_ready=0 -> out_valid=0, acc=0 next cycle, pending result dropped.
